// File: rtl/rx_pkt_dequeue.sv
// RX data FIFO read-side consumer: pops {status, data} words and presents
// framed packets to the host, dropping orphan words and closing cut-short frames.
module rx_pkt_dequeue #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25,
    input  logic [63:0]          rxdfifo_rdata,
    input  logic [7:0]           rxdfifo_rstatus,
    input  logic                 rxdfifo_rempty,
    input  logic                 rxdfifo_ralmost_empty,
    output logic                 rxdfifo_ren,
    input  logic                 pkt_rx_ren,
    output logic                 pkt_rx_avail,
    output logic                 pkt_rx_val,
    output logic [63:0]          pkt_rx_data,
    output logic                 pkt_rx_sop,
    output logic                 pkt_rx_eop,
    output logic                 pkt_rx_err,
    output logic [2:0]           pkt_rx_mod,
    output logic [CNT_WIDTH-1:0] stat_rx_drop_cnt,
    output logic [CNT_WIDTH-1:0] stat_rx_abort_cnt
);

    typedef enum logic [1:0] {IDLE, READ, DROP} state_t;

    state_t state, state_nxt;
    logic   head_sop, head_eop;
    logic   pop, emit, abort, drop_inc, avail_nxt;
    logic   status_unused;

    assign head_sop      = rxdfifo_rstatus[6] & ~rxdfifo_rempty;
    assign head_eop      = rxdfifo_rstatus[7] & ~rxdfifo_rempty;
    assign status_unused = ^rxdfifo_rstatus[4:3];

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        emit      = 1'b0;
        abort     = 1'b0;
        drop_inc  = 1'b0;
        avail_nxt = 1'b0;
        case (state)
            IDLE: begin
                // A multi-word frame only starts once enough of it is buffered.
                avail_nxt = head_sop & (~rxdfifo_ralmost_empty | head_eop);
                if (~rxdfifo_rempty & ~rxdfifo_rstatus[6]) begin
                    state_nxt = DROP;
                    drop_inc  = 1'b1;
                end else if (pkt_rx_ren & pkt_rx_avail & head_sop) begin
                    pop       = 1'b1;
                    emit      = 1'b1;
                    avail_nxt = 1'b0;
                    if (!head_eop) state_nxt = READ;
                end
            end
            READ: begin
                // A new SOP before EOP closes the current frame; the SOP stays queued.
                if (pkt_rx_ren & head_sop) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (pkt_rx_ren & ~rxdfifo_rempty) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                    if (head_eop) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (head_sop) begin
                    state_nxt = IDLE;
                end else if (!rxdfifo_rempty) begin
                    pop = 1'b1;
                    if (head_eop) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rxdfifo_ren = pop & ~reset_156m25;

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state             <= IDLE;
            pkt_rx_avail      <= 1'b0;
            pkt_rx_val        <= 1'b0;
            pkt_rx_data       <= '0;
            pkt_rx_sop        <= 1'b0;
            pkt_rx_eop        <= 1'b0;
            pkt_rx_err        <= 1'b0;
            pkt_rx_mod        <= '0;
            stat_rx_drop_cnt  <= '0;
            stat_rx_abort_cnt <= '0;
        end else begin
            state        <= state_nxt;
            pkt_rx_avail <= avail_nxt;
            pkt_rx_val   <= emit | abort;
            if (emit) begin
                pkt_rx_data <= rxdfifo_rdata;
                pkt_rx_sop  <= (state == IDLE);
                pkt_rx_eop  <= rxdfifo_rstatus[7];
                pkt_rx_err  <= rxdfifo_rstatus[5];
                pkt_rx_mod  <= rxdfifo_rstatus[2:0];
            end else if (abort) begin
                pkt_rx_data <= '0;
                pkt_rx_sop  <= 1'b0;
                pkt_rx_eop  <= 1'b1;
                pkt_rx_err  <= 1'b1;
                pkt_rx_mod  <= '0;
            end
            if (drop_inc && stat_rx_drop_cnt != '1)
                stat_rx_drop_cnt <= stat_rx_drop_cnt + CNT_WIDTH'(1);
            if (abort && stat_rx_abort_cnt != '1)
                stat_rx_abort_cnt <= stat_rx_abort_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/rx_pkt_dequeue.md
# rx_pkt_dequeue

Read-side consumer of the 72-bit RX data FIFO in the 156.25 MHz domain: pops `{status[7:0], data[63:0]}` words and presents them to the host as framed packets on the `pkt_rx_*` interface. Enforces frame integrity before the host sees anything. Words arriving outside a frame are discarded. A frame cut short by a new SOP is closed with an error-flagged terminating word. Sits between the RX data FIFO read port and the host packet interface.

## Interface
- `CNT_WIDTH`, 16: width of the saturating statistics counters.

Ports, clock and reset first:
- `clk_156m25`  in  1  core clock. This block uses one clock; the reset below is synchronous and active-high.
- `reset_156m25`  in  1  synchronous, active-high reset.
- `rxdfifo_rdata`  in  64  FIFO head data. Valid whenever `rxdfifo_rempty`=0 (early-read FIFO).
- `rxdfifo_rstatus`  in  8  FIFO head status: [7]=EOP, [6]=SOP, [5]=ERR, [2:0]=MOD (valid bytes in EOP word, 0 means 8).
- `rxdfifo_rempty`  in  1  FIFO empty.
- `rxdfifo_ralmost_empty`  in  1  FIFO holds ≤4 words.
- `rxdfifo_ren`  out  1  pop, combinational. Never asserted while `rxdfifo_rempty`=1.
- `pkt_rx_ren`  in  1  host read request.
- `pkt_rx_avail`  out  1  frame ready to start, registered.
- `pkt_rx_val`  out  1  output word valid, registered.
- `pkt_rx_data`  out  64  output data, registered.
- `pkt_rx_sop`, `pkt_rx_eop`, `pkt_rx_err`  out  1 each  frame flags, qualified by `pkt_rx_val`.
- `pkt_rx_mod`  out  3  byte count of the EOP word, qualified by `pkt_rx_eop`.
- `stat_rx_drop_cnt`  out  CNT_WIDTH  orphan-sequence count, saturating.
- `stat_rx_abort_cnt`  out  CNT_WIDTH  aborted-frame count, saturating.

## Operation
- Definitions used below:
  - `head_sop` = `rxdfifo_rstatus[6]` & ~`rxdfifo_rempty`.
  - `head_eop` = `rxdfifo_rstatus[7]` & ~`rxdfifo_rempty`.
- State machine: IDLE, READ, DROP. Reset state is IDLE.
- IDLE
  - `avail_next` = `head_sop` & (~`rxdfifo_ralmost_empty` | `head_eop`).
  - Non-empty head without SOP: go to DROP. Increment `stat_rx_drop_cnt` once on that entry.
  - `pkt_rx_ren` & `pkt_rx_avail` & `head_sop`: pop, emit the word with sop=1.
    - If that word has EOP: stay in IDLE (single-word frame).
    - Otherwise: go to READ.
- READ
  - Pop only when `pkt_rx_ren` & ~`rxdfifo_rempty` & ~`head_sop`.
  - Each popped word is emitted with sop=0, eop=status[7], err=status[5], mod=status[2:0].
  - Popped word has EOP: go to IDLE.
  - `head_sop` & `pkt_rx_ren` (abort):
    - Do not pop.
    - Emit one word: data=0, eop=1, err=1, mod=0.
    - Increment `stat_rx_abort_cnt`.
    - Go to IDLE. The pending SOP word starts the next frame normally.
  - `pkt_rx_ren`=0 or FIFO empty: no pop, `pkt_rx_val`=0 next cycle, state held (pause or underrun).
- DROP
  - Pop every cycle the FIFO is non-empty, regardless of `pkt_rx_ren`. Nothing is emitted.
  - Popped word has EOP: go to IDLE.
  - `head_sop` seen while in DROP: go to IDLE without popping.
- The block never pops past an EOP within a cycle. `pkt_rx_ren` held high after EOP has no effect until `pkt_rx_avail` rises again.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values, applied on the first clock edge with `reset_156m25`=1:
  - `pkt_rx_avail`, `pkt_rx_val`, `pkt_rx_sop`, `pkt_rx_eop`, `pkt_rx_err` = 0.
  - `pkt_rx_mod` = 0, `pkt_rx_data` = 0, both counters = 0.
  - State = IDLE.
  - `rxdfifo_ren` = 0 while reset is asserted.
- Reset mid-frame: the partial frame is abandoned and no EOP is emitted. FIFO contents are untouched. A leftover non-SOP head after reset goes through DROP.
- `pkt_rx_avail` is `avail_next` registered: rises 1 cycle after the condition, falls the cycle after the SOP pop, and is 0 in READ and DROP.
- Latency: the edge that samples `pkt_rx_ren`=1 with a pop presents that word on `pkt_rx_*` with `pkt_rx_val`=1 after that same edge (1 cycle, registered). One word per cycle maximum.
- `pkt_rx_val` is 0 on every cycle following a non-pop, non-abort cycle.
- Earliest restart after EOP: `pkt_rx_avail` is high again 1 cycle after the EOP pop (if the next SOP is already at the head), and the next SOP pops the cycle after that. Minimum gap between an EOP output and the next SOP output is 1 cycle.

## Test plan
- Frame of 4 words (SOP on word 0, EOP with MOD=5 on word 3), 8 words preloaded, `pkt_rx_ren` held high:
  - `pkt_rx_avail` rises, then 4 consecutive `pkt_rx_val` words with sop on the first and eop+mod=5 on the last.
  - The following frame does not start until `pkt_rx_avail` re-asserts.
- 3 orphan words (no SOP, last has EOP) followed by a valid frame:
  - 3 pops with no `pkt_rx_val`, `stat_rx_drop_cnt`=1, then the frame is delivered intact.
- SOP, 2 middle words, then a new SOP before any EOP:
  - 3 words delivered, then an abort word (data=0, eop=1, err=1, mod=0), `stat_rx_abort_cnt`=1, then the second frame delivered from its SOP.
- `pkt_rx_ren` dropped for 3 cycles mid-frame, and separately the FIFO run empty mid-frame:
  - `pkt_rx_val`=0 and no pops during the gap; the frame resumes without loss or duplication.
- Single-word frame (SOP+EOP, ERR=1, MOD=3):
  - One word with sop=eop=err=1, mod=3; state stays IDLE.
- Reset asserted in READ after 2 words, then released:
  - All outputs 0 on the next edge, remaining non-SOP words dropped with `stat_rx_drop_cnt`=1, the next SOP frame delivered normally.
- Drive more than 2^16 orphan sequences:
  - `stat_rx_drop_cnt` holds at 0xFFFF.
